// File: rtl/rll_2_7_write_serializer.sv
// rtl/rll_2_7_write_serializer.sv - RLL(2,7) code chunk buffer and write-pulse serializer
module rll_2_7_write_serializer #(
   parameter int CLK_DIV     = 4,
   parameter int PULSE_WIDTH = 2,
   parameter int PRIME_BITS  = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        write_enable,
   input  logic [15:0] code_in,
   input  logic [4:0]  code_bits,
   input  logic        code_valid,
   output logic        code_ready,
   output logic        wr_data,
   output logic        wr_gate,
   output logic        busy,
   output logic        underrun,
   output logic        rll_violation,
   input  logic        clear_status,
   output logic [15:0] cell_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int TW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PWW = $clog2(PULSE_WIDTH + 1);

   logic [1:0]     state;
   logic [31:0]    sreg;
   logic [5:0]     fill;
   logic [TW-1:0]  timer;
   logic [PWW-1:0] pulse_left;
   logic [3:0]     zeros;
   logic           seen_one;

   logic [4:0]  n_bits;
   logic [15:0] chunk;
   logic        accept;
   logic        tick;
   logic        empty;
   logic        pop;
   logic        cell_bit;
   logic        drain_done;
   logic        emit;
   logic [5:0]  fill_pop;
   logic [31:0] sreg_pop;
   logic [31:0] sreg_next;
   logic [5:0]  fill_next;
   logic [3:0]  zeros_inc;
   logic        viol_set;
   logic        underrun_set;

   assign code_ready = enable && (fill <= 6'd16);
   assign busy       = (state != ST_IDLE);

   always_comb begin
      n_bits       = (code_bits > 5'd16) ? 5'd16 : code_bits;
      chunk        = code_in & ~(16'hFFFF >> n_bits);
      accept       = code_valid && code_ready;
      tick         = (state != ST_IDLE) && (timer == TW'(CLK_DIV - 1));
      empty        = (fill == 6'd0);
      pop          = tick && !empty;
      cell_bit     = pop && sreg[31];
      // The empty tick that ends a drain closes the write; it is not a cell.
      drain_done   = tick && empty && (state == ST_DRAIN);
      emit         = tick && !drain_done;
      fill_pop     = fill - {5'd0, pop};
      sreg_pop     = pop ? {sreg[30:0], 1'b0} : sreg;
      sreg_next    = accept ? (sreg_pop | ({chunk, 16'h0000} >> fill_pop)) : sreg_pop;
      fill_next    = accept ? (fill_pop + {1'b0, n_bits}) : fill_pop;
      zeros_inc    = (zeros == 4'd15) ? 4'd15 : (zeros + 4'd1);
      viol_set     = emit && (cell_bit ? (seen_one && (zeros < 4'd2)) : (zeros_inc == 4'd8));
      underrun_set = tick && empty && (state == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         sreg          <= 32'd0;
         fill          <= 6'd0;
         timer         <= '0;
         pulse_left    <= '0;
         zeros         <= 4'd0;
         seen_one      <= 1'b0;
         wr_data       <= 1'b0;
         wr_gate       <= 1'b0;
         underrun      <= 1'b0;
         rll_violation <= 1'b0;
         cell_count    <= 16'd0;
      end else if (enable) begin
         sreg <= sreg_next;
         fill <= fill_next;

         case (state)
            ST_IDLE: begin
               if (write_enable && (fill >= 6'(PRIME_BITS))) begin
                  state      <= ST_RUN;
                  wr_gate    <= 1'b1;
                  timer      <= '0;
                  cell_count <= 16'd0;
                  zeros      <= 4'd0;
                  seen_one   <= 1'b0;
               end
            end
            ST_RUN, ST_DRAIN: begin
               timer <= tick ? '0 : (timer + 1'b1);
               if (emit) begin
                  cell_count <= cell_count + 16'd1;
                  if (cell_bit) begin
                     zeros    <= 4'd0;
                     seen_one <= 1'b1;
                  end else begin
                     zeros <= zeros_inc;
                  end
               end
               if (state == ST_RUN) begin
                  if (!write_enable) state <= ST_DRAIN;
               end else if (drain_done) begin
                  state   <= ST_IDLE;
                  wr_gate <= 1'b0;
               end else if (write_enable) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state   <= ST_IDLE;
               wr_gate <= 1'b0;
            end
         endcase

         // A '1' cell starts a pulse on the cycle after its tick.
         if (emit && cell_bit) begin
            wr_data    <= 1'b1;
            pulse_left <= PWW'(PULSE_WIDTH - 1);
         end else if (pulse_left != '0) begin
            pulse_left <= pulse_left - 1'b1;
         end else begin
            wr_data <= 1'b0;
         end

         underrun      <= underrun_set | (underrun & ~clear_status);
         rll_violation <= viol_set | (rll_violation & ~clear_status);
      end
   end

endmodule

// File: tb/tb_rll_2_7_write_serializer.sv
// tb/tb_rll_2_7_write_serializer.sv - directed self-checking bench for rll_2_7_write_serializer
module tb_rll_2_7_write_serializer;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        write_enable;
   logic [15:0] code_in;
   logic [4:0]  code_bits;
   logic        code_valid;
   logic        code_ready;
   logic        wr_data;
   logic        wr_gate;
   logic        busy;
   logic        underrun;
   logic        rll_violation;
   logic        clear_status;
   logic [15:0] cell_count;

   int checks;
   int failures;
   int cyc;
   int rise_q[$];
   logic wr_prev;

   rll_2_7_write_serializer #(
      .CLK_DIV(4),
      .PULSE_WIDTH(2),
      .PRIME_BITS(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .write_enable(write_enable),
      .code_in(code_in),
      .code_bits(code_bits),
      .code_valid(code_valid),
      .code_ready(code_ready),
      .wr_data(wr_data),
      .wr_gate(wr_gate),
      .busy(busy),
      .underrun(underrun),
      .rll_violation(rll_violation),
      .clear_status(clear_status),
      .cell_count(cell_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   initial wr_prev = 1'b0;
   always @(negedge clk) begin
      if (wr_data && !wr_prev) rise_q.push_back(cyc);
      wr_prev = wr_data;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [4:0] b);
      int k;
      code_in    = d;
      code_bits  = b;
      code_valid = 1'b1;
      k = 0;
      while (!code_ready && k < 200) begin
         step(1);
         k++;
      end
      check("push_ready", 32'(code_ready), 32'd1);
      step(1);
      code_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (busy && k < bound) begin
         step(1);
         k++;
      end
      check("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic pulse_clear();
      clear_status = 1'b1;
      step(1);
      clear_status = 1'b0;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset_n      = 1'b0;
      enable       = 1'b1;
      write_enable = 1'b0;
      code_in      = 16'h0000;
      code_bits    = 5'd0;
      code_valid   = 1'b0;
      clear_status = 1'b0;
      step(2);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_wr_gate", 32'(wr_gate), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_flags", 32'({underrun, rll_violation}), 32'd0);
      check("rst_cell_count", 32'(cell_count), 32'd0);
      reset_n = 1'b1;
      step(1);

      // 10010000: pulses at cells 0 and 3, drain to idle
      rise_q.delete();
      write_enable = 1'b1;
      push(16'h9000, 5'd8);
      step(1);
      check("t1_gate", 32'(wr_gate), 32'd1);
      write_enable = 1'b0;
      wait_idle(100);
      check("t1_rises", 32'(rise_q.size()), 32'd2);
      if (rise_q.size() == 2) check("t1_spacing", 32'(rise_q[1] - rise_q[0]), 32'd12);
      check("t1_cells", 32'(cell_count), 32'd8);
      check("t1_flags", 32'({underrun, rll_violation}), 32'd0);
      check("t1_gate_off", 32'(wr_gate), 32'd0);

      // underrun at the 9th tick
      write_enable = 1'b1;
      push(16'h9200, 5'd8);
      step(1);
      step(35);
      check("t2_no_underrun", 32'(underrun), 32'd0);
      step(1);
      check("t2_underrun", 32'(underrun), 32'd1);
      check("t2_cells9", 32'(cell_count), 32'd9);
      check("t2_gate", 32'(wr_gate), 32'd1);
      check("t2_rll", 32'(rll_violation), 32'd0);
      step(8);
      check("t2_cells11", 32'(cell_count), 32'd11);
      write_enable = 1'b0;
      wait_idle(100);
      check("t2_sticky", 32'(underrun), 32'd1);
      pulse_clear();
      check("t2_cleared", 32'({underrun, rll_violation}), 32'd0);

      // d=2 violation at cell 1
      write_enable = 1'b1;
      push(16'hC000, 5'd8);
      step(1);
      step(7);
      check("t3_no_viol", 32'(rll_violation), 32'd0);
      step(1);
      check("t3_d_viol", 32'(rll_violation), 32'd1);
      write_enable = 1'b0;
      wait_idle(100);
      pulse_clear();
      check("t3_cleared", 32'(rll_violation), 32'd0);

      // k=7 violation at cell 8
      write_enable = 1'b1;
      push(16'h8000, 5'd9);
      step(1);
      step(35);
      check("t3_no_kviol", 32'(rll_violation), 32'd0);
      step(1);
      check("t3_k_viol", 32'(rll_violation), 32'd1);
      write_enable = 1'b0;
      wait_idle(100);
      check("t3_no_underrun", 32'(underrun), 32'd0);
      pulse_clear();

      // fill to 32, zero-length chunk in between
      write_enable = 1'b0;
      push(16'h9249, 5'd16);
      check("t4_ready16", 32'(code_ready), 32'd1);
      push(16'hFFFF, 5'd0);
      check("t4_ready_zero_chunk", 32'(code_ready), 32'd1);
      push(16'h2492, 5'd16);
      check("t4_full", 32'(code_ready), 32'd0);
      write_enable = 1'b1;
      step(1);
      check("t4_run", 32'(busy), 32'd1);
      step(63);
      check("t4_not_ready", 32'(code_ready), 32'd0);
      step(1);
      check("t4_ready_back", 32'(code_ready), 32'd1);
      write_enable = 1'b0;
      wait_idle(200);
      check("t4_cells32", 32'(cell_count), 32'd32);
      check("t4_rll", 32'(rll_violation), 32'd0);

      // 10 bits then immediate drain
      write_enable = 1'b1;
      push(16'h9240, 5'd10);
      step(1);
      write_enable = 1'b0;
      step(43);
      check("t5_busy", 32'(busy), 32'd1);
      check("t5_cells", 32'(cell_count), 32'd10);
      step(1);
      check("t5_idle", 32'(busy), 32'd0);
      check("t5_gate", 32'(wr_gate), 32'd0);
      check("t5_cells_final", 32'(cell_count), 32'd10);
      check("t5_underrun", 32'(underrun), 32'd0);

      // reset mid-pulse
      write_enable = 1'b1;
      push(16'hC000, 5'd8);
      step(1);
      step(8);
      check("t6_pulse", 32'(wr_data), 32'd1);
      check("t6_viol", 32'(rll_violation), 32'd1);
      reset_n = 1'b0;
      write_enable = 1'b0;
      step(1);
      check("t6_wr_data", 32'(wr_data), 32'd0);
      check("t6_wr_gate", 32'(wr_gate), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_flags", 32'({underrun, rll_violation}), 32'd0);
      check("t6_cells", 32'(cell_count), 32'd0);
      reset_n = 1'b1;
      step(1);
      push(16'h9249, 5'd16);
      check("t6_fill_empty", 32'(code_ready), 32'd1);
      push(16'h2492, 5'd16);
      check("t6_fill32", 32'(code_ready), 32'd0);

      // enable low freezes everything
      enable = 1'b0;
      write_enable = 1'b1;
      step(5);
      check("t7_frozen_idle", 32'(busy), 32'd0);
      check("t7_ready_low", 32'(code_ready), 32'd0);
      enable = 1'b1;
      step(1);
      check("t7_run", 32'(busy), 32'd1);
      step(2);
      enable = 1'b0;
      step(10);
      check("t7_frozen_cells", 32'(cell_count), 32'd0);
      check("t7_gate_held", 32'(wr_gate), 32'd1);
      enable = 1'b1;
      step(2);
      check("t7_resume", 32'(cell_count), 32'd1);
      write_enable = 1'b0;
      wait_idle(400);
      check("t7_cells32", 32'(cell_count), 32'd32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
